vip_multi_target_detect_n: RTL and testbench
============================================

# vip_multi_target_detect_n

Parametrised multi-target bounding-box detector for the binarised video path. It consumes a 1-bit foreground stream plus frame/line/pixel strobes and tracks up to TARGET_NUM rectangular targets per frame. Pixels within a programmable neighbourhood of an existing target are merged into that target; other pixels open a new slot. It sits after the binarisation/morphology stage and feeds the box-overlay and target-selection logic. All results are latched once per frame.

## Interface
- IMG_HDISP, 1280, active pixels per line
- IMG_VDISP, 720, active lines per frame
- TARGET_NUM, 4, target slots (1..16)
- XW, 11, x coordinate width
- YW, 10, y coordinate width
- MIN_AREA, 16, minimum pixel count for a valid target (used only with MTD_AREA_EN)
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- per_frame_vsync  in  1  high during the active frame
- per_frame_href  in  1  line valid; informational, not used for counting
- per_frame_clken  in  1  pixel strobe
- per_img_bit  in  1  foreground pixel
- min_dist  in  10  merge neighbourhood radius in pixels
- target_pos_out  out  TARGET_NUM*W  slot i at [i*W +: W], W=1+2*XW+2*YW, {valid, ymax, xmax, ymin, xmin}
- target_cnt_out  out  5  number of valid slots in the last frame
- overflow_out  out  1  last frame needed a slot when none was free
- frame_done  out  1  one-cycle pulse when outputs update
- target_area_out  out  TARGET_NUM*21  per-slot pixel count (only with MTD_AREA_EN)

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, LATCH. The FSM resets to IDLE.
- IDLE → ACTIVE on a vsync rising edge (vsync=1, vsync_r=0). On entry, all slots, the overflow flag and the counters clear.
- ACTIVE → DRAIN on a vsync falling edge. DRAIN lasts 2 cycles, then LATCH lasts 1 cycle, then the FSM returns to IDLE.
- If rst_n deasserts while vsync is high, the FSM stays in IDLE until the next rising edge, so a partial frame is never reported.
- Coordinate counters run only in ACTIVE:
  - x increments on clken and wraps at IMG_HDISP-1.
  - On wrap, y increments; y saturates at IMG_VDISP-1.
- Stage 1 registers {clken & bit, x, y}.
- Stage 2 (foreground pixel): compare the pixel against each valid slot's window [xmin-min_dist, xmax+min_dist] × [ymin-min_dist, ymax+min_dist].
  - Subtraction saturates at 0. Addition saturates at IMG_HDISP-1 / IMG_VDISP-1.
  - Compute at max(XW,YW)+1 bits so no wrap occurs.
- Match: expand the lowest-index matching slot only, using min/max on each edge.
- No match, free slot exists: allocate the lowest-index free slot with the box set to the point and valid=1.
- No match, no free slot: drop the pixel and set overflow.
- Comparison uses the current slot registers. A stage-2 update is visible to the very next pixel, so back-to-back foreground pixels need no stall.
- LATCH copies the slots to target_pos_out, popcount(valid) to target_cnt_out and overflow to overflow_out, and pulses frame_done.
- Output reset values are all 0.

## Timing
- Pixel at input edge t: registered at t+1, slot updated at t+2.
- A vsync falling edge sampled at edge k: DRAIN at k+1 and k+2, outputs and frame_done update at k+3.
- Outputs hold stable between frame_done pulses.
- A vsync rising edge during DRAIN or LATCH is deferred; the frame starts in IDLE at the next rising edge.
- Asynchronous reset mid-operation clears all state and outputs immediately.

## Configuration
- MTD_AREA_EN defined:
  - Each slot carries a 21-bit pixel counter (saturating), incremented on allocate and merge.
  - In LATCH, a slot with area < MIN_AREA has valid forced to 0 and is excluded from target_cnt_out.
  - target_area_out is present.
- MTD_AREA_EN undefined: no counters, no filtering, no target_area_out port; valid reflects allocation only.

## Test plan
- Single 10×10 blob at x=100..109, y=50..59, min_dist=4 → slot0 = {1,59,109,50,100}, cnt=1, overflow=0, frame_done at k+3.
- Two blobs at x=100 and x=600, same rows, min_dist=4 → slot0 and slot1 hold the distinct boxes, cnt=2.
- Blobs whose gap is 3 px, min_dist=4 → merged into slot0; with min_dist=2 → two slots.
- TARGET_NUM+1 isolated single pixels 50 px apart → first TARGET_NUM valid, overflow_out=1; corner pixels (0,0) and (1279,719) produce no window wrap.
- rst_n pulse mid-frame, then release while vsync high → no frame_done until a full subsequent frame; the following frame reports correctly.
- MTD_AREA_EN, MIN_AREA=16: 3×3 blob plus 5×5 blob → only the 5×5 is valid, its area=25, cnt=1.

Source files
------------

// File: rtl/vip_multi_target_detect_n_if.sv
// -----------------------------------------------------------------------------
// vip_multi_target_detect_n_if
// Binarised video stream bundle feeding the multi-target detector.
//   per_frame_vsync : high during the active frame
//   per_frame_href  : line valid (informational only, not read by the detector)
//   per_frame_clken : pixel strobe
//   per_img_bit     : foreground pixel
// Modports: master = video source, slave = detector.
// -----------------------------------------------------------------------------
interface vip_multi_target_detect_n_if;
   logic per_frame_vsync;
   logic per_frame_href;
   logic per_frame_clken;
   logic per_img_bit;

   modport master (
      output per_frame_vsync,
      output per_frame_href,
      output per_frame_clken,
      output per_img_bit
   );

   // href carries no information the detector needs, so the slave side omits it.
   modport slave (
      input per_frame_vsync,
      input per_frame_clken,
      input per_img_bit
   );
endinterface

// File: rtl/vip_multi_target_detect_n.sv
// -----------------------------------------------------------------------------
// vip_multi_target_detect_n
// Multi-target bounding-box detector for the binarised video path. Tracks up
// to TARGET_NUM rectangles per frame; foreground pixels inside the min_dist
// neighbourhood of a live slot grow that slot, others open a new slot.
// Results are latched once per frame.
//
// Ports:
//   clk, rst_n       : pixel clock, asynchronous active-low reset
//   vin (slave)      : vsync / clken / foreground bit stream
//   min_dist         : merge neighbourhood radius in pixels
//   target_pos_out   : slot i at [i*W +: W], {valid, ymax, xmax, ymin, xmin}
//   target_cnt_out   : number of valid slots in the last frame
//   overflow_out     : last frame needed a slot when none was free
//   frame_done       : one-cycle pulse when the outputs update
//   target_area_out  : per-slot pixel count (MTD_AREA_EN only)
//
// Build option: define MTD_AREA_EN to add per-slot area counters, the
// MIN_AREA validity filter and the target_area_out port.
// -----------------------------------------------------------------------------
module vip_multi_target_detect_n #(
   parameter int IMG_HDISP  = 1280,
   parameter int IMG_VDISP  = 720,
   parameter int TARGET_NUM = 4,
   parameter int XW         = 11,
   parameter int YW         = 10,
   parameter int MIN_AREA   = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   vip_multi_target_detect_n_if.slave        vin,
   input  logic [9:0]                        min_dist,
   output logic [TARGET_NUM*(1+2*XW+2*YW)-1:0] target_pos_out,
   output logic [4:0]                        target_cnt_out,
   output logic                              overflow_out,
   output logic                              frame_done
`ifdef MTD_AREA_EN
   ,
   output logic [TARGET_NUM*21-1:0]          target_area_out
`endif
);

   localparam int W  = 1 + 2*XW + 2*YW;
   localparam int MW = (XW > YW) ? XW : YW;
   localparam int CW = ((MW > 10) ? MW : 10) + 1;
   localparam int SW = (TARGET_NUM > 1) ? $clog2(TARGET_NUM) : 1;
   localparam logic [CW-1:0] XLIM = CW'(IMG_HDISP - 1);
   localparam logic [CW-1:0] YLIM = CW'(IMG_VDISP - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, LATCH} state_t;

   function automatic logic [CW-1:0] sub_sat(input logic [CW-1:0] a, input logic [CW-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   function automatic logic [CW-1:0] add_sat(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                             input logic [CW-1:0] lim);
      logic [CW-1:0] s;
      s = a + b;
      return (s > lim) ? lim : s;
   endfunction

   function automatic logic in_win(input logic [CW-1:0] p, input logic [CW-1:0] lo_edge,
                                   input logic [CW-1:0] hi_edge, input logic [CW-1:0] md,
                                   input logic [CW-1:0] lim);
      return (p >= sub_sat(lo_edge, md)) && (p <= add_sat(hi_edge, md, lim));
   endfunction

   state_t          state_q, state_d;
   logic            drain_q;
   logic            vsync_r;
   logic            start;
   logic [XW-1:0]   x_cnt;
   logic [YW-1:0]   y_cnt;

   logic            vld_p1;
   logic [XW-1:0]   x_p1;
   logic [YW-1:0]   y_p1;

   logic            slot_vld_p2 [TARGET_NUM];
   logic [XW-1:0]   xmin_p2     [TARGET_NUM];
   logic [XW-1:0]   xmax_p2     [TARGET_NUM];
   logic [YW-1:0]   ymin_p2     [TARGET_NUM];
   logic [YW-1:0]   ymax_p2     [TARGET_NUM];
   logic            ovf_p2;
`ifdef MTD_AREA_EN
   logic [20:0]     area_p2     [TARGET_NUM];
`endif

   logic            hit, free_ok;
   logic [SW-1:0]   hit_idx, free_idx;
   logic [TARGET_NUM-1:0] vf;
   logic [4:0]      cnt_c;
   logic [CW-1:0]   md;

   assign md    = CW'(min_dist);
   assign start = (state_q == IDLE) && vin.per_frame_vsync && !vsync_r;

   // vsync_r resets high so a reset released mid-frame never looks like a frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         drain_q <= 1'b0;
         vsync_r <= 1'b1;
      end else begin
         state_q <= state_d;
         drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
         vsync_r <= vin.per_frame_vsync;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vin.per_frame_vsync && !vsync_r) state_d = ACTIVE;
         ACTIVE:  if (!vin.per_frame_vsync && vsync_r) state_d = DRAIN;
         DRAIN:   if (drain_q) state_d = LATCH;
         LATCH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (start) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (state_q == ACTIVE && vin.per_frame_clken) begin
         if (x_cnt == XW'(IMG_HDISP - 1)) begin
            x_cnt <= '0;
            if (y_cnt != YW'(IMG_VDISP - 1)) y_cnt <= y_cnt + 1'b1;
         end else begin
            x_cnt <= x_cnt + 1'b1;
         end
      end
   end

   // ---- stage 1: register foreground strobe and its coordinates ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         x_p1   <= '0;
         y_p1   <= '0;
      end else begin
         vld_p1 <= (state_q == ACTIVE) && vin.per_frame_clken && vin.per_img_bit;
         x_p1   <= x_cnt;
         y_p1   <= y_cnt;
      end
   end

   // ---- stage 2: window match against live slots, then grow/allocate ----
   // Scanning downward leaves the lowest matching and lowest free index.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_ok  = 1'b0;
      free_idx = '0;
      for (int i = TARGET_NUM - 1; i >= 0; i--) begin
         if (slot_vld_p2[i] &&
             in_win(CW'(x_p1), CW'(xmin_p2[i]), CW'(xmax_p2[i]), md, XLIM) &&
             in_win(CW'(y_p1), CW'(ymin_p2[i]), CW'(ymax_p2[i]), md, YLIM)) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
         if (!slot_vld_p2[i]) begin
            free_ok  = 1'b1;
            free_idx = SW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_p2 <= 1'b0;
         for (int i = 0; i < TARGET_NUM; i++) begin
            slot_vld_p2[i] <= 1'b0;
            xmin_p2[i] <= '0; xmax_p2[i] <= '0; ymin_p2[i] <= '0; ymax_p2[i] <= '0;
`ifdef MTD_AREA_EN
            area_p2[i] <= '0;
`endif
         end
      end else if (start) begin
         ovf_p2 <= 1'b0;
         for (int i = 0; i < TARGET_NUM; i++) begin
            slot_vld_p2[i] <= 1'b0;
            xmin_p2[i] <= '0; xmax_p2[i] <= '0; ymin_p2[i] <= '0; ymax_p2[i] <= '0;
`ifdef MTD_AREA_EN
            area_p2[i] <= '0;
`endif
         end
      end else if (vld_p1) begin
         if (hit) begin
            if (x_p1 < xmin_p2[hit_idx]) xmin_p2[hit_idx] <= x_p1;
            if (x_p1 > xmax_p2[hit_idx]) xmax_p2[hit_idx] <= x_p1;
            if (y_p1 < ymin_p2[hit_idx]) ymin_p2[hit_idx] <= y_p1;
            if (y_p1 > ymax_p2[hit_idx]) ymax_p2[hit_idx] <= y_p1;
`ifdef MTD_AREA_EN
            if (area_p2[hit_idx] != '1) area_p2[hit_idx] <= area_p2[hit_idx] + 1'b1;
`endif
         end else if (free_ok) begin
            slot_vld_p2[free_idx] <= 1'b1;
            xmin_p2[free_idx] <= x_p1; xmax_p2[free_idx] <= x_p1;
            ymin_p2[free_idx] <= y_p1; ymax_p2[free_idx] <= y_p1;
`ifdef MTD_AREA_EN
            area_p2[free_idx] <= 21'd1;
`endif
         end else begin
            ovf_p2 <= 1'b1;
         end
      end
   end

   // ---- frame latch: final validity, popcount and output registers ----
   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < TARGET_NUM; i++) begin
`ifdef MTD_AREA_EN
         vf[i] = slot_vld_p2[i] && (area_p2[i] >= 21'(MIN_AREA));
`else
         vf[i] = slot_vld_p2[i];
`endif
         cnt_c = cnt_c + 5'(vf[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_pos_out  <= '0;
         target_cnt_out  <= '0;
         overflow_out    <= 1'b0;
         frame_done      <= 1'b0;
`ifdef MTD_AREA_EN
         target_area_out <= '0;
`endif
      end else begin
         frame_done <= (state_q == LATCH);
         if (state_q == LATCH) begin
            for (int i = 0; i < TARGET_NUM; i++) begin
               target_pos_out[i*W +: W] <= {vf[i], ymax_p2[i], xmax_p2[i], ymin_p2[i], xmin_p2[i]};
`ifdef MTD_AREA_EN
               target_area_out[i*21 +: 21] <= area_p2[i];
`endif
            end
            target_cnt_out <= cnt_c;
            overflow_out   <= ovf_p2;
         end
      end
   end

endmodule

// File: tb/tb_vip_multi_target_detect_n.sv
// -----------------------------------------------------------------------------
// tb_vip_multi_target_detect_n
// Directed bench for vip_multi_target_detect_n on a reduced 128x64 raster so
// every frame stays short; the blob geometry is scaled to fit that raster.
// With MTD_AREA_EN defined the area-filter frame checks the filtered result.
// -----------------------------------------------------------------------------
module tb_vip_multi_target_detect_n;
   localparam int HD = 128;
   localparam int VD = 64;
   localparam int TN = 4;
   localparam int W  = 43;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [9:0]       min_dist = 10'd4;
   logic [TN*W-1:0]  tpos;
   logic [4:0]       tcnt;
   logic             tovf;
   logic             fd;
`ifdef MTD_AREA_EN
   logic [TN*21-1:0] tarea;
`endif

   int vectors = 0;
   int miscompares = 0;
   int mode = 0;

   vip_multi_target_detect_n_if vif ();

   vip_multi_target_detect_n #(
      .IMG_HDISP(HD), .IMG_VDISP(VD), .TARGET_NUM(TN), .XW(11), .YW(10), .MIN_AREA(16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vin            (vif),
      .min_dist       (min_dist),
      .target_pos_out (tpos),
      .target_cnt_out (tcnt),
      .overflow_out   (tovf),
      .frame_done     (fd)
`ifdef MTD_AREA_EN
      ,
      .target_area_out(tarea)
`endif
   );

   always #5 clk = ~clk;

   assign vif.per_frame_href = vif.per_frame_vsync & vif.per_frame_clken;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] box(input int v, input int ymax, input int xmax,
                                        input int ymin, input int xmin);
      return {v[0], ymax[9:0], xmax[10:0], ymin[9:0], xmin[10:0]};
   endfunction

   function automatic logic fg(input int m, input int x, input int y);
      case (m)
         1: return (x >= 100 && x <= 109 && y >= 50 && y <= 59);
         2: return (y >= 5 && y <= 14) && ((x >= 10 && x <= 19) || (x >= 100 && x <= 109));
         3: return (y >= 5 && y <= 14) && ((x >= 10 && x <= 19) || (x >= 23 && x <= 32));
         4: return (y == 0 && (x == 0 || x == 3 || x == 50 || x == 100)) ||
                   (x == 25 && y == 50) || (x == 127 && y == 63);
         6: return (x >= 10 && x <= 12 && y >= 5 && y <= 7) ||
                   (x >= 40 && x <= 44 && y >= 5 && y <= 9);
         default: return 1'b0;
      endcase
   endfunction

   // Stream npix pixels of the current pattern, close the frame and check
   // that frame_done arrives exactly three edges after the vsync fall.
   task automatic run_frame(input string tag, input int npix);
      int px, py;
      px = 0; py = 0;
      @(negedge clk);
      vif.per_frame_vsync = 1'b1;
      vif.per_frame_clken = 1'b0;
      vif.per_img_bit     = 1'b0;
      for (int p = 0; p < npix; p++) begin
         @(negedge clk);
         vif.per_frame_clken = 1'b1;
         vif.per_img_bit     = fg(mode, px, py);
         if (px == HD - 1) begin
            px = 0;
            if (py != VD - 1) py++;
         end else begin
            px++;
         end
      end
      @(negedge clk);
      vif.per_frame_clken = 1'b0;
      vif.per_img_bit     = 1'b0;
      vif.per_frame_vsync = 1'b0;
      @(posedge clk); #1 check({tag, "_fd_k"}, 64'(fd), 64'd0);
      @(posedge clk);
      @(posedge clk); #1 check({tag, "_fd_k2"}, 64'(fd), 64'd0);
      @(posedge clk); #1 check({tag, "_fd_k3"}, 64'(fd), 64'd1);
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3,
                            input int cnt, input int ovf);
      check({tag, "_slot0"}, 64'(tpos[0*W +: W]), 64'(e0));
      check({tag, "_slot1"}, 64'(tpos[1*W +: W]), 64'(e1));
      check({tag, "_slot2"}, 64'(tpos[2*W +: W]), 64'(e2));
      check({tag, "_slot3"}, 64'(tpos[3*W +: W]), 64'(e3));
      check({tag, "_cnt"},   64'(tcnt), 64'(cnt));
      check({tag, "_ovf"},   64'(tovf), 64'(ovf));
      @(posedge clk); #1 check({tag, "_fd_pulse"}, 64'(fd), 64'd0);
   endtask

   initial begin
      int fd_seen;
      vif.per_frame_vsync = 1'b0;
      vif.per_frame_clken = 1'b0;
      vif.per_img_bit     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_pos", 64'(tpos[W-1:0]) | 64'(tpos[TN*W-1:W] != '0), 64'd0);
      check("rst_cnt", 64'(tcnt), 64'd0);
      check("rst_ovf", 64'(tovf), 64'd0);
      check("rst_fd",  64'(fd),   64'd0);

      // single 10x10 blob
      mode = 1; min_dist = 10'd4;
      run_frame("blob1", 59*HD + 110);
      check_out("blob1", box(1,59,109,50,100), '0, '0, '0, 1, 0);

      // two distant blobs on the same rows
      mode = 2;
      run_frame("blob2", 14*HD + 110);
      check_out("blob2", box(1,14,19,5,10), box(1,14,109,5,100), '0, '0, 2, 0);

      // 3 px gap: merges with radius 4, separates with radius 2
      mode = 3; min_dist = 10'd4;
      run_frame("gap4", 14*HD + 110);
      check_out("gap4", box(1,14,32,5,10), '0, '0, '0, 1, 0);
      min_dist = 10'd2;
      run_frame("gap2", 14*HD + 110);
      check_out("gap2", box(1,14,19,5,10), box(1,14,32,5,23), '0, '0, 2, 0);

      // TN+1 isolated points incl. both corners; (3,0) must merge into (0,0)
      mode = 4; min_dist = 10'd4;
      run_frame("ovf", HD*VD);
      check_out("ovf", box(1,0,3,0,0), box(1,0,50,0,50), box(1,0,100,0,100),
                box(1,50,25,50,25), 4, 1);

      // reset pulse mid-frame, released while vsync is still high
      mode = 1;
      @(negedge clk);
      vif.per_frame_vsync = 1'b1;
      for (int p = 0; p < 3000; p++) begin
         @(negedge clk);
         vif.per_frame_clken = 1'b1;
         vif.per_img_bit     = 1'b0;
      end
      #1 check("hold_cnt", 64'(tcnt), 64'd4);
      check("hold_ovf", 64'(tovf), 64'd1);
      rst_n = 1'b0;
      #1 check("arst_cnt", 64'(tcnt), 64'd0);
      check("arst_ovf", 64'(tovf), 64'd0);
      check("arst_slot0", 64'(tpos[0*W +: W]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fd_seen = 0;
      for (int p = 0; p < 2000; p++) begin
         @(negedge clk);
         vif.per_img_bit = (p % 3 == 0);
         if (fd) fd_seen++;
      end
      vif.per_frame_clken = 1'b0;
      vif.per_img_bit     = 1'b0;
      vif.per_frame_vsync = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (fd) fd_seen++;
      end
      check("rst_no_done", 64'(fd_seen), 64'd0);
      check("rst_cnt_idle", 64'(tcnt), 64'd0);

      run_frame("after_rst", 59*HD + 110);
      check_out("after_rst", box(1,59,109,50,100), '0, '0, '0, 1, 0);

      // 3x3 and 5x5 blobs: area filter decides the first slot's validity
      mode = 6;
      run_frame("area", 9*HD + 45);
`ifdef MTD_AREA_EN
      check_out("area", box(0,7,12,5,10), box(1,9,44,5,40), '0, '0, 1, 0);
      check("area_a0", 64'(tarea[0*21 +: 21]), 64'd9);
      check("area_a1", 64'(tarea[1*21 +: 21]), 64'd25);
`else
      check_out("area", box(1,7,12,5,10), box(1,9,44,5,40), '0, '0, 2, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
